count_run_ctrl: RTL and testbench
=================================

// Module: count_run_ctrl
// PURPOSE
//  Run controller for the board's WIDTH-bit pin counter (drives p3A* LED/pin bank).
//  Accepts a limit/prescale/mode config via valid/ready handshake, then sequences the
//  counter: start, stop, prescaled stepping, wrap or one-shot terminate, tc pulse.
//  Sits between host/switch logic and the output pins; the sole owner of the count value.
// PARAMETERS
//  WIDTH       4  counter width (bits)
//  PRESCALE_W  8  prescale field width; step every (cfg_prescale+1) clocks
// PORTS
//  p3B2          in   1           clock; all logic on rising edge
//  p3B3          in   1           reset, synchronous, active-low
//  cfg_valid     in   1           config offered
//  cfg_ready     out  1           config accepted when cfg_valid&cfg_ready at edge
//  cfg_limit     in   WIDTH       terminal count value
//  cfg_prescale  in   PRESCALE_W  clocks-per-step minus 1
//  cfg_oneshot   in   1           1: stop at limit; 0: wrap to 0 and continue
//  start         in   1           level sampled per edge; begin run
//  stop          in   1           level sampled per edge; abort run
//  count         out  WIDTH       current count (registered)
//  tc            out  1           terminal-count pulse (registered)
//  busy          out  1           state==RUN
//  done          out  1           state==DONE
// BEHAVIOUR
//  - Reset (p3B3 low at edge, overrides all inputs): state IDLE, count 0, tc 0, pre 0,
//    limit all-ones, prescale 0, oneshot 0. Thus busy 0, done 0, cfg_ready 1.
//  - States IDLE, RUN, DONE. cfg_ready = (state!=RUN), combinational from state.
//  - Config accept (IDLE or DONE): limit/prescale/oneshot regs load at that edge; state->IDLE,
//    count->0, done clears. start in same cycle is ignored (config wins).
//  - IDLE/DONE + start (no cfg accept): state->RUN, count->0, pre->0. stop ignored here.
//  - RUN, each edge, priority order:
//     1. stop=1: state->IDLE, count holds, pre->0, no tc. start ignored in RUN.
//     2. pre!=prescale: pre->pre+1.
//     3. pre==prescale (step): pre->0; if count==limit: tc->1 and
//        oneshot ? (state->DONE, count holds at limit) : count->0;
//        else count->count+1 (modulo 2^WIDTH never reached since count<=limit).
//  - tc is 1 only in the cycle after a terminal step edge; else 0. Consecutive terminal
//    steps (limit 0, prescale 0, freerun) keep tc high continuously.
//  - Step period = prescale+1 clocks; freerun wrap period = (limit+1)*(prescale+1) clocks.
//  - limit 0: oneshot -> DONE with tc after prescale+1 clocks; freerun -> count stays 0.
//  - Config changes only outside RUN; running parameters are never altered mid-run.
//  - Reset mid-run: next edge with p3B3 low returns all regs (incl. config) to reset values.
// TESTING
//  1. p3B3 low 2 edges with start=1,cfg_valid=1 -> count 0, tc 0, busy 0, done 0, cfg_ready 1.
//  2. Defaults, start 1 edge -> count 1..15 on edges 1..15, edge 16 count 0 & tc=1 one cycle;
//     repeats every 16 clocks, busy stays 1.
//  3. cfg limit 3, prescale 2, oneshot 1; start -> count 1,2,3 at edges 3,6,9; edge 12:
//     done 1, busy 0, tc 1 one cycle, count holds 3; cfg_ready 1.
//  4. Freerun run, stop at count 5 -> next edge busy 0, count 5, no tc; cfg_valid during RUN
//     sees cfg_ready 0 and nothing loads; later start restarts from 0.
//  5. cfg limit 0, prescale 0, freerun; start -> count stays 0, tc high every cycle from edge 1.
//  6. Run with limit 9 to count 7, pull p3B3 low one edge -> count 0, busy 0, tc 0, limit back
//     to 15 (verify by start: wrap at edge 16).

Source files
------------

// File: rtl/count_run_ctrl.sv
// Run controller for a WIDTH-bit pin counter: takes a limit/prescale/mode config over a
// valid/ready handshake and sequences start, stop, prescaled stepping, wrap/one-shot and tc.
module count_run_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                  p3B2,
  input  logic                  p3B3,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_oneshot,
  input  logic                  start,
  input  logic                  stop,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [WIDTH-1:0]      count_n;
  logic                  tc_n;
  logic [PRESCALE_W-1:0] pre, pre_n;
  logic [WIDTH-1:0]      limit, limit_n;
  logic [PRESCALE_W-1:0] prescale, prescale_n;
  logic                  oneshot, oneshot_n;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed by the combinational block, independent of ordering.
  always_ff @(posedge p3B2) begin
    if (!p3B3) begin
      state    <= IDLE;
      count    <= '0;
      tc       <= 1'b0;
      pre      <= '0;
      limit    <= '1;
      prescale <= '0;
      oneshot  <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      tc       <= tc_n;
      pre      <= pre_n;
      limit    <= limit_n;
      prescale <= prescale_n;
      oneshot  <= oneshot_n;
    end
  end

  // NOTE: every output of this block is given a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    count_n    = count;
    tc_n       = 1'b0;
    pre_n      = pre;
    limit_n    = limit;
    prescale_n = prescale;
    oneshot_n  = oneshot;

    unique case (state)
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          pre_n   = '0;
        end else if (pre != prescale) begin
          pre_n = pre + 1'b1;
        end else begin
          pre_n = '0;
          if (count == limit) begin
            tc_n = 1'b1;
            if (oneshot) state_n = DONE;
            else         count_n = '0;
          end else begin
            count_n = count + 1'b1;
          end
        end
      end
      default: begin
        // Config wins over start; the counter only ever runs with settled parameters.
        if (cfg_valid) begin
          limit_n    = cfg_limit;
          prescale_n = cfg_prescale;
          oneshot_n  = cfg_oneshot;
          state_n    = IDLE;
          count_n    = '0;
          pre_n      = '0;
        end else if (start) begin
          state_n = RUN;
          count_n = '0;
          pre_n   = '0;
        end
      end
    endcase
  end

  assign cfg_ready = (state != RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_count_run_ctrl.sv
// Scoreboard bench for count_run_ctrl: an elapsed-time arithmetic model predicts each
// edge's outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_count_run_ctrl;

  localparam int WIDTH      = 4;
  localparam int PRESCALE_W = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [WIDTH-1:0]      cfg_limit;
  logic [PRESCALE_W-1:0] cfg_prescale;
  logic                  cfg_oneshot;
  logic                  start;
  logic                  stop;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  busy;
  logic                  done;

  always #5 clk = ~clk;

  count_run_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .p3B2        (clk),
    .p3B3        (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_limit   (cfg_limit),
    .cfg_prescale(cfg_prescale),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .stop        (stop),
    .count       (count),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int count;
    int tc;
    int busy;
    int done;
    int ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a run is described by edges elapsed since start (m_k); the count
  // and tc follow from integer division of that time by the step period.
  int m_mode;  // 0 idle, 1 run, 2 done
  int m_k, m_L, m_P, m_O, m_count, m_tc;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_edge();
    int steps;
    bit on_step;
    if (!rst_n) begin
      m_mode = 0; m_count = 0; m_tc = 0;
      m_L = (1 << WIDTH) - 1; m_P = 0; m_O = 0;
    end else if (m_mode != 1) begin
      m_tc = 0;
      if (cfg_valid) begin
        m_L = int'(cfg_limit); m_P = int'(cfg_prescale); m_O = int'(cfg_oneshot);
        m_mode = 0; m_count = 0;
      end else if (start) begin
        m_mode = 1; m_k = 0; m_count = 0;
      end
    end else if (stop) begin
      m_mode = 0; m_tc = 0;
    end else begin
      m_k++;
      steps   = m_k / (m_P + 1);
      on_step = (m_k % (m_P + 1)) == 0;
      if (m_O != 0 && steps == m_L + 1) begin
        m_mode = 2; m_count = m_L; m_tc = 1;
      end else begin
        m_count = steps % (m_L + 1);
        m_tc    = (on_step && steps > 0 && (steps % (m_L + 1)) == 0) ? 1 : 0;
      end
    end
  endtask

  task automatic drive(input logic r, input logic cv, input logic st, input logic sp,
                       input int lim, input int pre, input logic os, input int n);
    exp_t e;
    repeat (n) begin
      #1;
      rst_n = r; cfg_valid = cv; start = st; stop = sp;
      cfg_limit = WIDTH'(lim); cfg_prescale = PRESCALE_W'(pre); cfg_oneshot = os;
      @(posedge clk);
      model_edge();
      e.count = m_count; e.tc = m_tc;
      e.busy  = (m_mode == 1) ? 1 : 0;
      e.done  = (m_mode == 2) ? 1 : 0;
      e.ready = (m_mode != 1) ? 1 : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, n);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", int'(count), e.count);
        check("tc", int'(tc), e.tc);
        check("busy", int'(busy), e.busy);
        check("done", int'(done), e.done);
        check("cfg_ready", int'(cfg_ready), e.ready);
      end
    end
  end

  initial begin : stimulus
    // Reset dominates start and cfg_valid.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 5, 3, 1'b1, 2);
    idle(2);
    // Default config: 0..15 wrap with tc every 16 clocks.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1);
    idle(40);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1);
    // One-shot: limit 3, prescale 2.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3, 2, 1'b1, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1);
    idle(15);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1);   // stop is ignored in DONE
    // Freerun limit 9; cfg offered mid-run must not load; stop at count 5.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 9, 0, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1);
    idle(2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 2, 1, 1'b1, 3);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1);
    idle(2);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1);
    idle(12);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1);
    // Limit 0, prescale 0, freerun: tc every cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1);
    idle(5);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1);
    // Reset mid-run restores default limit.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 9, 0, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1);
    idle(7);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1);
    idle(20);
    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3)),
            logic'($urandom_range(0, 1)),
            1);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
